// File: rtl/pv_sampler.sv
// pv_sampler: periodic process-value sampler sitting between the SPI input
// master and the PID core.
//
// Every PERIOD clk cycles (while enable=1) the sampler requests one SPI
// transaction. It detects completion from the master's chip-select, captures
// the received word as the process value and presents {pv, setpoint - pv} to
// the PID core over a valid/ready handshake. A sample period that has to be
// skipped sets the sticky overrun flag.
//
// Build option: define PV_SAMPLER_AVG_EN to run two back-to-back SPI
// transactions per sample and report their truncated mean as the process value.

module pv_sampler #(
   parameter  int BITS   = 4,                // SPI word / pv / setpoint width
   parameter  int PERIOD = 64,               // sample period in clk cycles (>= 8)
   localparam int PBITS  = $clog2(PERIOD)    // period counter width
) (
   input  logic            clk,
   input  logic            reset,            // synchronous, active-high
   input  logic            enable,           // 1 = ticks may launch samples
   input  logic [BITS-1:0] setpoint,         // unsigned target value
   input  logic            spi_cs,           // SPI chip-select: 1 = idle, 0 = busy
   input  logic [BITS-1:0] spi_data,         // SPI master output buffer
   output logic            spi_start,        // start request to the SPI master
   output logic            out_valid,        // sample available
   input  logic            out_ready,        // consumer accepts sample
   output logic [BITS-1:0] out_pv,           // captured process value
   output logic [BITS:0]   out_err,          // signed setpoint - pv
   output logic            overrun           // sticky: a sample tick was skipped
);

   // Sampling sequencer states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,   // waiting for the next period tick
      START     = 2'd1,   // one-cycle start request to the SPI master
      WAIT_BUSY = 2'd2,   // waiting for chip-select to go low
      WAIT_DONE = 2'd3    // waiting for chip-select to return high
   } state_t;

   localparam logic [PBITS-1:0] CNT_LAST = PBITS'(PERIOD - 1);

   state_t            state_q,   state_d;
   logic [PBITS-1:0]  cnt_q,     cnt_d;
   logic              valid_q,   valid_d;
   logic [BITS-1:0]   pv_q,      pv_d;
   logic [BITS:0]     err_q,     err_d;
   logic              overrun_q, overrun_d;

   logic              tick;         // period boundary while enabled
   logic              capture;      // load a new sample into the output register
   logic [BITS-1:0]   cap_pv;       // process value to be captured

`ifdef PV_SAMPLER_AVG_EN
   logic [BITS-1:0]   acc_q,         acc_d;          // first word of the pair
   logic              pair_second_q, pair_second_d;  // 1 = second transaction running
   logic [BITS:0]     pair_sum;

   // Full-width sum of the two words; the mean is its upper BITS bits.
   assign pair_sum = {1'b0, acc_q} + {1'b0, spi_data};
   assign cap_pv   = pair_sum[BITS:1];
`else
   assign cap_pv   = spi_data;
`endif

   assign tick = (cnt_q == CNT_LAST) && enable;

   // Period counter: free-running 0..PERIOD-1 while enabled, parked at 0 otherwise.
   always_comb begin
      cnt_d = cnt_q;
      if (!enable) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Sequencer next state, output register and overrun tracking.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; a missing default here would infer a latch.
      state_d   = state_q;
      valid_d   = valid_q;
      pv_d      = pv_q;
      err_d     = err_q;
      overrun_d = overrun_q;
      capture   = 1'b0;
`ifdef PV_SAMPLER_AVG_EN
      acc_d         = acc_q;
      pair_second_d = pair_second_q;
`endif

      // Consumer takes the sample; a capture later in this block overrides.
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      // A tick outside IDLE cannot launch anything and is lost.
      if (tick && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (tick) begin
               if (valid_q && !out_ready) begin
                  // Previous sample still unread: skip rather than overwrite it.
                  overrun_d = 1'b1;
               end else begin
                  state_d = START;
               end
            end
         end

         START: begin
            state_d = WAIT_BUSY;
         end

         WAIT_BUSY: begin
            if (!spi_cs) begin
               state_d = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            if (spi_cs) begin
`ifdef PV_SAMPLER_AVG_EN
               if (!pair_second_q) begin
                  // First word of the pair: keep it and run the second transaction.
                  acc_d         = spi_data;
                  pair_second_d = 1'b1;
                  state_d       = START;
               end else begin
                  pair_second_d = 1'b0;
                  capture       = 1'b1;
                  state_d       = IDLE;
               end
`else
               capture = 1'b1;
               state_d = IDLE;
`endif
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (capture) begin
         pv_d    = cap_pv;
         err_d   = {1'b0, setpoint} - {1'b0, cap_pv};
         valid_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: flops are updated with non-blocking assignments so every register
      // samples the values from before this edge, independent of statement order.
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         pv_q      <= '0;
         err_q     <= '0;
         overrun_q <= 1'b0;
`ifdef PV_SAMPLER_AVG_EN
         acc_q         <= '0;
         pair_second_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         pv_q      <= pv_d;
         err_q     <= err_d;
         overrun_q <= overrun_d;
`ifdef PV_SAMPLER_AVG_EN
         acc_q         <= acc_d;
         pair_second_q <= pair_second_d;
`endif
      end
   end

   assign spi_start = (state_q == START);
   assign out_valid = valid_q;
   assign out_pv    = pv_q;
   assign out_err   = err_q;
   assign overrun   = overrun_q;

endmodule

// File: doc/pv_sampler.md
Name: pv_sampler

Overview:
- Sits directly upstream of the SPI input master and downstream of it on the data side.
- Issues periodic start requests to the SPI master and detects transaction completion from its chip-select.
- Captures the received process-value word, computes error = setpoint − pv and presents both to the PID core over a valid/ready handshake.
- Flags sample periods it had to skip (overrun).

Parameters:
- BITS, 4, width of SPI data word, process value and setpoint.
- PERIOD, 64, sample period in clk cycles (≥ 8).
- PBITS, $clog2(PERIOD), period counter width (derived; not overridden).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = period ticks may launch samples; 0 = no new samples launched.
- setpoint  input  BITS  unsigned target value, sampled when pv is captured.
- spi_cs  input  1  SPI master chip-select; 1 = idle, 0 = busy.
- spi_data  input  BITS  SPI master output buffer.
- spi_start  output  1  start request to SPI master.
- out_valid  output  1  sample available.
- out_ready  input  1  consumer accepts sample.
- out_pv  output  BITS  captured process value.
- out_err  output  BITS+1  signed two's complement error, setpoint − pv, zero-extended operands.
- overrun  output  1  sticky: a sample tick was skipped.

Behaviour:
- Reset: spi_start=0, out_valid=0, out_pv=0, out_err=0, overrun=0, period counter=0, FSM=IDLE.
- Period counter:
  - Free-running whenever enable=1 (held at 0 when enable=0); counts 0..PERIOD-1 and wraps.
  - tick = (cnt == PERIOD-1) && enable.
- FSM states and transitions:
  - IDLE:
    - On tick, if out_valid=1 && !(out_ready) → skip the sample, overrun<=1, stay IDLE.
    - Otherwise on tick → START.
  - START: spi_start=1 for exactly one cycle; next state WAIT_BUSY.
  - WAIT_BUSY: spi_start=0. When spi_cs==0 → WAIT_DONE.
  - WAIT_DONE: when spi_cs==1 → out_pv<=spi_data, out_err<=setpoint−spi_data, out_valid<=1 → IDLE. The capture cycle is the first cycle spi_cs is seen high.
- Ticks arriving in any state other than IDLE are lost; set overrun<=1.
- Handshake:
  - Transfer occurs when out_valid && out_ready; out_valid<=0 on the next edge unless a capture happens in the same cycle, in which case the capture wins (out_valid stays 1, new data).
  - out_pv/out_err are stable while out_valid=1 and not accepted.
- Arithmetic: out_err = {1'b0,setpoint} − {1'b0,pv} in BITS+1 bits; range −(2^BITS−1)..+(2^BITS−1). No saturation needed.
- Deassert enable mid-transaction: the current transaction completes and captures normally; no further launches.
- Reset mid-transaction: immediate return to reset values; the SPI master is reset by the same reset.
- overrun is cleared only by reset.
- Latency from tick to out_valid: 2 + SPI transaction length + 1 cycles.

Optional Feature:
- Macro PV_SAMPLER_AVG_EN.
- Defined:
  - Each sample runs two back-to-back SPI transactions. After the first WAIT_DONE, store spi_data in an accumulator and return to START; the second completion captures pv = (first + second) >> 1 (BITS+1-bit sum, truncating shift).
  - out_err uses the averaged pv.
  - An internal flag tracks which transaction of the pair is in progress; it is cleared by reset.
- Undefined: single transaction per sample, as above; no accumulator logic synthesized.

Test Plan:
- Reset, enable=1, setpoint=4'd9, SPI model returns 4'd5 → single spi_start pulse at cycle 64 after reset release (cnt wrap); out_valid rises on the first cycle spi_cs returns high; out_pv=5, out_err=+4 (5'b00100).
- setpoint=0, data=4'hF → out_err=5'b10001 (−15); setpoint=4'hF, data=0 → out_err=+15.
- Hold out_ready=0 across two periods → second tick skipped, no spi_start, overrun=1, out_pv unchanged; raise out_ready → out_valid drops next cycle.
- Model holds spi_cs low for longer than PERIOD → tick during WAIT_DONE sets overrun; a single capture follows, with no extra start.
- Assert reset while in WAIT_DONE → all outputs return to 0 the next cycle; enable=0 → no spi_start for 3 periods.
- With PV_SAMPLER_AVG_EN, data sequence 6 then 9 → two spi_start pulses, out_pv=7, setpoint=7 → out_err=0.
